// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, next-PC selection and a req/gnt/rvalid
// handshake to instruction memory, with sticky misalign and timeout faults.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  input  logic        i_advance,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic [31:0] o_instr,
  output logic        o_instr_vld,
  output logic        o_misalign,
  output logic        o_timeout
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StReq, StWait, StValid, StFault} state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [31:0]     instr_q;
  logic            req_q;
  logic            vld_q;
  logic            misalign_q;
  logic            timeout_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     pc_target;

  // Jump targets always have bit 0 cleared, so that bit is never looked at.
  logic unused_alu_bit0;
  assign unused_alu_bit0 = i_alu_data[0];

  always_comb begin
    pc_target = i_pc_sel ? {i_alu_data[31:1], 1'b0} : pc_q + 32'd4;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      instr_q    <= Nop;
      req_q      <= 1'b1;
      vld_q      <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        StReq: begin
          if (i_imem_gnt) begin
            req_q <= 1'b0;
            if (i_imem_rvalid) begin
              instr_q <= i_imem_rdata;
              vld_q   <= 1'b1;
              state_q <= StValid;
            end else begin
              cnt_q   <= '0;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (i_imem_rvalid) begin
            instr_q <= i_imem_rdata;
            vld_q   <= 1'b1;
            state_q <= StValid;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // Checking the pre-increment count still accepts rvalid in the last wait cycle.
            if (TIMEOUT != 0 && cnt_q == CntLast) begin
              timeout_q <= 1'b1;
              state_q   <= StFault;
            end
          end
        end
        StValid: begin
          if (i_advance) begin
            vld_q <= 1'b0;
            if (pc_target[1]) begin
              misalign_q <= 1'b1;
              state_q    <= StFault;
            end else begin
              pc_q    <= pc_target;
              req_q   <= 1'b1;
              state_q <= StReq;
            end
          end
        end
        default: begin
          req_q   <= 1'b0;
          vld_q   <= 1'b0;
          state_q <= StFault;
        end
      endcase
    end
  end

  assign o_imem_req  = req_q;
  assign o_imem_addr = pc_q;
  assign o_pc        = pc_q;
  assign o_pc_four   = pc_q + 32'd4;
  assign o_instr     = instr_q;
  assign o_instr_vld = vld_q;
  assign o_misalign  = misalign_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// fetch/branch stream checked against a transaction-level PC model.
module tb_instr_fetch;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam int unsigned To    = 16;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pc_sel = 1'b0;
  logic [31:0] i_alu_data = '0;
  logic        i_advance = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic [31:0] o_instr;
  logic        o_instr_vld;
  logic        o_misalign;
  logic        o_timeout;

  int checks = 0;
  int failures = 0;

  instr_fetch #(
    .RESET_PC(RstPc),
    .TIMEOUT (To)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pc_sel     (i_pc_sel),
    .i_alu_data   (i_alu_data),
    .i_advance    (i_advance),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_gnt   (i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_pc         (o_pc),
    .o_pc_four    (o_pc_four),
    .o_instr      (o_instr),
    .o_instr_vld  (o_instr_vld),
    .o_misalign   (o_misalign),
    .o_timeout    (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_advance = 1'b0; i_pc_sel = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic fetch_zero(input logic [31:0] word);
    i_imem_gnt = 1'b1; i_imem_rvalid = 1'b1; i_imem_rdata = word;
    tick();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
  endtask

  task automatic advance(input logic sel, input logic [31:0] alu);
    i_advance = 1'b1; i_pc_sel = sel; i_alu_data = alu;
    tick();
    i_advance = 1'b0; i_pc_sel = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_imem_gnt = 1'b1; i_imem_rvalid = 1'b1; i_advance = 1'b1;
    tick(); tick();
    i_reset = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_advance = 1'b0;
    checks++; if (o_imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", o_imem_req); end
    checks++; if (o_imem_addr !== RstPc) begin failures++; $display("FAIL reset_addr got=%h exp=%h", o_imem_addr, RstPc); end
    checks++; if (o_instr !== Nop) begin failures++; $display("FAIL reset_instr got=%h exp=%h", o_instr, Nop); end
    checks++; if (o_instr_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", o_instr_vld); end
    checks++; if ({o_misalign, o_timeout} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {o_misalign, o_timeout}); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    fetch_zero(32'h0050_0093);
    checks++; if (o_instr_vld !== 1'b1) begin failures++; $display("FAIL zw_vld got=%b exp=1", o_instr_vld); end
    checks++; if (o_instr !== 32'h0050_0093) begin failures++; $display("FAIL zw_instr got=%h exp=00500093", o_instr); end
    checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL zw_pc got=%h exp=0", o_pc); end
    checks++; if (o_pc_four !== 32'h4) begin failures++; $display("FAIL zw_pc_four got=%h exp=4", o_pc_four); end
    checks++; if (o_imem_req !== 1'b0) begin failures++; $display("FAIL zw_req got=%b exp=0", o_imem_req); end
  endtask

  task automatic test_advance();
    advance(1'b0, 32'hDEAD_BEEF);
    checks++; if (o_instr_vld !== 1'b0) begin failures++; $display("FAIL adv_vld got=%b exp=0", o_instr_vld); end
    checks++; if (o_imem_req !== 1'b1) begin failures++; $display("FAIL adv_req got=%b exp=1", o_imem_req); end
    checks++; if (o_imem_addr !== 32'h4) begin failures++; $display("FAIL adv_addr got=%h exp=4", o_imem_addr); end
  endtask

  task automatic test_branch();
    fetch_zero($urandom);
    advance(1'b1, 32'h0000_0101);
    checks++; if (o_imem_addr !== 32'h100) begin failures++; $display("FAIL br_addr got=%h exp=100", o_imem_addr); end
    checks++; if (o_imem_req !== 1'b1) begin failures++; $display("FAIL br_req got=%b exp=1", o_imem_req); end
  endtask

  task automatic test_misalign();
    fetch_zero($urandom);
    advance(1'b1, 32'h0000_0102);
    checks++; if (o_misalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", o_misalign); end
    checks++; if (o_pc !== 32'h100) begin failures++; $display("FAIL mis_pc got=%h exp=100", o_pc); end
    for (int k = 0; k < 12; k++) begin
      i_imem_gnt = 1'($urandom); i_imem_rvalid = 1'($urandom); i_advance = 1'($urandom);
      i_pc_sel = 1'($urandom); i_alu_data = $urandom & 32'hFFFF_FFF8;
      tick();
      checks++;
      if ({o_imem_req, o_instr_vld, o_misalign} !== 3'b001) begin
        failures++; $display("FAIL mis_hold k=%0d got req/vld/mis=%b exp=001", k, {o_imem_req, o_instr_vld, o_misalign});
      end
    end
    do_reset();
    checks++; if (o_misalign !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", o_misalign); end
  endtask

  task automatic test_wait_accept();
    do_reset();
    i_imem_gnt = 1'b1; tick(); i_imem_gnt = 1'b0;
    checks++; if (o_imem_req !== 1'b0) begin failures++; $display("FAIL wait_req got=%b exp=0", o_imem_req); end
    for (int k = 1; k < To; k++) tick();
    checks++; if ({o_instr_vld, o_timeout} !== 2'b00) begin failures++; $display("FAIL wait_pre got=%b exp=00", {o_instr_vld, o_timeout}); end
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'h1234_5677; tick(); i_imem_rvalid = 1'b0;
    checks++; if (o_instr_vld !== 1'b1) begin failures++; $display("FAIL wait_last_vld got=%b exp=1", o_instr_vld); end
    checks++; if (o_instr !== 32'h1234_5677) begin failures++; $display("FAIL wait_last_instr got=%h exp=12345677", o_instr); end
    checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL wait_last_to got=%b exp=0", o_timeout); end
  endtask

  task automatic test_timeout();
    do_reset();
    i_imem_gnt = 1'b1; tick(); i_imem_gnt = 1'b0;
    for (int k = 1; k < To; k++) tick();
    checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", o_timeout); end
    tick();
    checks++; if (o_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", o_timeout); end
    i_imem_gnt = 1'b1; i_imem_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
    checks++;
    if ({o_imem_req, o_instr_vld, o_timeout} !== 3'b001) begin
      failures++; $display("FAIL to_hold got req/vld/to=%b exp=001", {o_imem_req, o_instr_vld, o_timeout});
    end
    do_reset();
    checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", o_timeout); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    fetch_zero($urandom);
    advance(1'b1, 32'h0000_0040);
    checks++; if (o_imem_addr !== 32'h40) begin failures++; $display("FAIL rmw_addr40 got=%h exp=40", o_imem_addr); end
    i_imem_gnt = 1'b1; tick(); i_imem_gnt = 1'b0;
    tick();
    i_reset = 1'b1; i_imem_rvalid = 1'b1; tick(); i_reset = 1'b0; i_imem_rvalid = 1'b0;
    checks++;
    if ({o_imem_req, o_instr_vld, o_misalign, o_timeout} !== 4'b1000) begin
      failures++; $display("FAIL rmw_state got req/vld/mis/to=%b exp=1000", {o_imem_req, o_instr_vld, o_misalign, o_timeout});
    end
    checks++; if (o_imem_addr !== RstPc) begin failures++; $display("FAIL rmw_addr got=%h exp=%h", o_imem_addr, RstPc); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_zero($urandom);
    advance(1'b1, 32'hFFFF_FFFC);
    fetch_zero($urandom);
    checks++; if (o_pc_four !== 32'h0) begin failures++; $display("FAIL wrap_pc_four got=%h exp=0", o_pc_four); end
    advance(1'b0, '0);
    checks++; if (o_imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", o_imem_addr); end
    checks++; if ({o_imem_req, o_misalign} !== 2'b10) begin failures++; $display("FAIL wrap_state got=%b exp=10", {o_imem_req, o_misalign}); end
  endtask

  // Transaction-level model: each fetch returns the word memory delivered, the PC
  // advances by 4 or to the even-rounded target, and a target with bit 1 set faults.
  task automatic test_random();
    logic [31:0] mpc, word, tgt, nxt;
    logic        sel;
    int          gdly, lat, idle;
    do_reset();
    mpc = RstPc;
    for (int n = 0; n < 60; n++) begin
      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== mpc) begin
        failures++; $display("FAIL rnd_req n=%0d got req=%b addr=%h exp req=1 addr=%h", n, o_imem_req, o_imem_addr, mpc);
      end
      gdly = $urandom_range(0, 3);
      for (int k = 0; k < gdly; k++) begin
        i_imem_rvalid = 1'($urandom); i_imem_rdata = $urandom; tick();
      end
      word = $urandom;
      lat = $urandom_range(0, To);
      i_imem_gnt = 1'b1; i_imem_rvalid = (lat == 0); i_imem_rdata = word;
      tick();
      i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
      if (lat > 0) begin
        for (int k = 1; k < lat; k++) begin
          i_imem_rdata = $urandom; tick();
        end
        i_imem_rdata = word; i_imem_rvalid = 1'b1; tick(); i_imem_rvalid = 1'b0;
      end
      checks++;
      if (o_instr_vld !== 1'b1 || o_instr !== word || o_pc !== mpc || o_pc_four !== mpc + 32'd4) begin
        failures++;
        $display("FAIL rnd_fetch n=%0d got vld=%b instr=%h pc=%h pc4=%h exp vld=1 instr=%h pc=%h pc4=%h",
                 n, o_instr_vld, o_instr, o_pc, o_pc_four, word, mpc, mpc + 32'd4);
      end
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        i_imem_rvalid = 1'b1; i_imem_rdata = $urandom; tick();
      end
      i_imem_rvalid = 1'b0;
      checks++;
      if (o_instr_vld !== 1'b1 || o_instr !== word) begin
        failures++; $display("FAIL rnd_hold n=%0d got vld=%b instr=%h exp vld=1 instr=%h", n, o_instr_vld, o_instr, word);
      end
      sel = 1'($urandom);
      tgt = $urandom;
      tgt[1] = ($urandom_range(0, 5) == 0);
      nxt = sel ? {tgt[31:1], 1'b0} : mpc + 32'd4;
      advance(sel, tgt);
      if (nxt[1]) begin
        checks++;
        if (o_misalign !== 1'b1 || o_imem_req !== 1'b0 || o_instr_vld !== 1'b0 || o_pc !== mpc) begin
          failures++;
          $display("FAIL rnd_mis n=%0d got mis=%b req=%b vld=%b pc=%h exp mis=1 req=0 vld=0 pc=%h",
                   n, o_misalign, o_imem_req, o_instr_vld, o_pc, mpc);
        end
        do_reset();
        mpc = RstPc;
      end else begin
        checks++;
        if (o_misalign !== 1'b0 || o_instr_vld !== 1'b0) begin
          failures++; $display("FAIL rnd_adv n=%0d got mis=%b vld=%b exp mis=0 vld=0", n, o_misalign, o_instr_vld);
        end
        mpc = nxt;
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_advance();
    test_branch();
    test_misalign();
    test_wait_accept();
    test_timeout();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
